cam_pixel_sequencer: RTL and testbench
======================================

Name: cam_pixel_sequencer

Overview:
- Sits directly upstream of happy_feet.
- Converts the raw camera raster (frame-valid / line-valid / data-valid strobes plus 12-bit RGB) into the pixel stream happy_feet consumes: pixel_r/g/b, pixel_valid, x, y.
- Owns frame alignment, coordinate counting, clipping of malformed lines and frames, and per-frame status reporting.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- SKIP_N, 2, frame decimation factor; used only when FRAME_SKIP_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- cam_fval  in  1  frame valid.
- cam_lval  in  1  line valid.
- cam_dval  in  1  pixel data valid; qualified by cam_lval.
- cam_r, cam_g, cam_b  in  12 each  camera colour samples.
- pixel_r, pixel_g, pixel_b  out  12 each, signed  pixel colour to happy_feet.
- pixel_valid  out  1  pixel qualifier.
- x  out  $clog2(IMG_WIDTH)  column of current pixel.
- y  out  $clog2(IMG_HEIGHT)  row of current pixel.
- frame_done  out  1  one-cycle pulse at end of a forwarded frame.
- frame_err  out  1  status for the last frame; valid with frame_done, held until the next frame_done.
- frame_cnt  out  16  count of completed forwarded frames; wraps at 0xFFFF -> 0.

Behaviour:
- All outputs registered. Latency 1 cycle from a sampled camera pixel to pixel_valid/x/y/pixel_*.
- Reset values (rst_n low at a clock edge): pixel_* = 0, pixel_valid = 0, x = 0, y = 0, frame_done = 0, frame_err = 0, frame_cnt = 0, FSM = SYNC.
- FSM states:
  - SYNC: wait for cam_fval == 0, then go to IDLE. Prevents starting mid-frame after reset.
  - IDLE: on the cam_fval rising edge go to ACTIVE and clear col, row and the err flag.
  - ACTIVE: process pixels; on cam_fval falling go to DONE.
  - DONE: one cycle; pulse frame_done, update frame_err and frame_cnt, return to IDLE.
- ACTIVE pixel rule: cam_lval & cam_dval & col < IMG_WIDTH & row < IMG_HEIGHT -> forward the pixel with x = col, y = row, then col++.
- Out-of-range pixels (col >= IMG_WIDTH or row >= IMG_HEIGHT): not forwarded and err set. col saturates at IMG_WIDTH.
- cam_lval falling edge with col > 0: if col != IMG_WIDTH set err; then col = 0 and row++ (saturating at IMG_HEIGHT).
- cam_lval pulses carrying no dval (col == 0): ignored; row is not incremented.
- cam_fval falling while cam_lval is high: treated as a line end (line rule applies), then the frame end.
- At DONE: frame_err = err | (row != IMG_HEIGHT).
- x/y hold rule: whenever pixel_valid is 0, x and y are driven to 0 and pixel_* hold their last value. The last-pixel coordinate (IMG_WIDTH-1, IMG_HEIGHT-1) therefore never lingers into the inter-frame gap.
- Simultaneous cam_fval rising in the same cycle as DONE: cannot occur (DONE lasts one cycle and needs fval low). A rising edge seen in DONE is latched and taken in IDLE the next cycle, with no pixel loss: the first pixel cannot arrive until lval rises.
- Reset mid-frame: all outputs return to reset values and the FSM goes to SYNC. The rest of that frame is discarded and not counted.
- Camera samples are reinterpreted as signed 12-bit with no modification.

Optional Feature:
- Macro: FRAME_SKIP_EN.
- Defined:
  - A modulo-SKIP_N phase counter advances at each cam_fval rising edge; only phase-0 frames are forwarded.
  - For skipped frames: pixel_valid stays 0, no frame_done pulse, no frame_cnt change, frame_err is held.
  - Reset sets the phase to 0, so the first frame after reset is forwarded.
- Not defined: every aligned frame is forwarded and the SKIP_N parameter is ignored.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4 unless stated):
1. Clean frame, 4 lines x 8 pixels, pixel value = 16*row+col.
   - 32 pixel_valid cycles, each with x=col, y=row and the matching value, 1-cycle latency.
   - Then frame_done for 1 cycle, frame_err = 0, frame_cnt = 1, and x = y = 0 afterward.
2. Reset deasserted while cam_fval = 1, mid-frame.
   - No pixel_valid until fval drops and rises again; that next frame gives frame_cnt = 1.
3. Line of 10 pixels on row 1.
   - Only cols 0-7 forwarded; frame_done with frame_err = 1.
   - A following clean frame gives frame_err = 0.
4. Frame with 3 lines, one line of 6 pixels, and an lval pulse with no dval.
   - Empty pulse ignored; frame_err = 1 with row = 3.
5. rst_n pulsed low at row 2 col 3, followed by 2 clean frames.
   - All outputs return to zero; frame_cnt ends at 2.
6. FRAME_SKIP_EN defined, SKIP_N=2, 5 clean frames.
   - Frames 1, 3, 5 forwarded; 3 frame_done pulses; frame_cnt = 3; no pixel_valid during frames 2 and 4.

Source files
------------

// File: rtl/cam_pixel_sequencer.sv
// Camera raster to happy_feet pixel stream: frame alignment, x/y counting, clipping, per-frame status.
// Optional build macro FRAME_SKIP_EN forwards only every SKIP_N-th aligned frame.
module cam_pixel_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int SKIP_N     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cam_fval,
  input  logic                          cam_lval,
  input  logic                          cam_dval,
  input  logic [11:0]                   cam_r,
  input  logic [11:0]                   cam_g,
  input  logic [11:0]                   cam_b,
  output logic signed [11:0]            pixel_r,
  output logic signed [11:0]            pixel_g,
  output logic signed [11:0]            pixel_b,
  output logic                          pixel_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  x,
  output logic [$clog2(IMG_HEIGHT)-1:0] y,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT);

  if (SKIP_N < 1) begin : g_skip_chk
    $error("SKIP_N must be at least 1");
  end

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_err;
  logic            r_fwd;
  logic            r_fval_q;
  logic            r_lval_q;

  logic            w_fval_fall;
  logic            w_line_end;
  logic            w_pix;
  logic            w_in_range;
  logic            w_fwd_start;

  assign w_fval_fall = r_fval_q & ~cam_fval;
  // A frame end with an open line closes that line first.
  assign w_line_end  = ((r_lval_q & ~cam_lval) | w_fval_fall) & (r_col != '0);
  assign w_pix       = cam_fval & cam_lval & cam_dval;
  assign w_in_range  = (r_col < COL_MAX) && (r_row < ROW_MAX);

`ifdef FRAME_SKIP_EN
  localparam int PW = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;
  logic [PW-1:0] r_phase;
  assign w_fwd_start = (r_phase == '0);
`else
  assign w_fwd_start = 1'b1;
`endif

  // Frame FSM, coordinate counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SYNC;
      r_col       <= '0;
      r_row       <= '0;
      r_err       <= 1'b0;
      r_fwd       <= 1'b0;
      r_fval_q    <= 1'b0;
      r_lval_q    <= 1'b0;
      pixel_r     <= 12'sd0;
      pixel_g     <= 12'sd0;
      pixel_b     <= 12'sd0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
`ifdef FRAME_SKIP_EN
      r_phase     <= '0;
`endif
    end else begin
      r_fval_q    <= cam_fval;
      r_lval_q    <= cam_lval;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      case (r_state)
        SYNC: begin
          if (!cam_fval) begin
            r_state <= IDLE;
          end
        end
        // IDLE is only entered with fval low, so a high level here is a fresh
        // rising edge, including one that arrived during DONE.
        IDLE: begin
          if (cam_fval) begin
            r_state <= ACTIVE;
            r_col   <= '0;
            r_row   <= '0;
            r_err   <= 1'b0;
            r_fwd   <= w_fwd_start;
`ifdef FRAME_SKIP_EN
            r_phase <= (r_phase == PW'(SKIP_N - 1)) ? '0 : r_phase + PW'(1);
`endif
          end
        end
        ACTIVE: begin
          if (w_fval_fall) begin
            r_state <= DONE;
          end
          if (w_line_end) begin
            if (r_col != COL_MAX) begin
              r_err <= 1'b1;
            end
            r_col <= '0;
            if (r_row < ROW_MAX) begin
              r_row <= r_row + RW'(1);
            end
          end else if (w_pix) begin
            if (w_in_range) begin
              r_col       <= r_col + CW'(1);
              pixel_valid <= r_fwd;
              if (r_fwd) begin
                x       <= r_col[XW-1:0];
                y       <= r_row[YW-1:0];
                pixel_r <= $signed(cam_r);
                pixel_g <= $signed(cam_g);
                pixel_b <= $signed(cam_b);
              end
            end else begin
              r_err <= 1'b1;
              if (r_col < COL_MAX) begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (r_fwd) begin
            frame_done <= 1'b1;
            frame_err  <= r_err | (r_row != ROW_MAX);
            frame_cnt  <= frame_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_sequencer.sv
// Directed bench for cam_pixel_sequencer (8x4 image) with pixel and frame-status scoreboards.
module tb_cam_pixel_sequencer;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fval = 1'b0, lval = 1'b0, dval = 1'b0;
  logic [11:0] cr = 12'd0, cg = 12'd0, cb = 12'd0;
  logic signed [11:0] pixel_r, pixel_g, pixel_b;
  logic        pixel_valid;
  logic [2:0]  x;
  logic [1:0]  y;
  logic        frame_done, frame_err;
  logic [15:0] frame_cnt;

  cam_pixel_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_N(SKIP)) dut (
    .clk(clk), .rst_n(rst_n), .cam_fval(fval), .cam_lval(lval), .cam_dval(dval),
    .cam_r(cr), .cam_g(cg), .cam_b(cb),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b), .pixel_valid(pixel_valid),
    .x(x), .y(y), .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] x, y, r, g, b; int cyc; } pix_t;
  typedef struct { logic [31:0] err, cnt; int cyc; } done_t;

  pix_t  pix_q[$];
  done_t done_q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    phase = 0;
  int    exp_cnt = 0;
  bit    mon_en = 1'b0;
  logic [31:0] last_err = 32'd0, last_cnt = 32'd0;
  pix_t  mp;
  done_t md;
  bit    exp_v, exp_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle counter and reset tracking on posedge; output checks on negedge.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
        mon_en   = 1'b1;
        pix_q.delete();
        done_q.delete();
        last_err = 32'd0;
        last_cnt = 32'd0;
      end
    end else if (mon_en) begin
      exp_v = (pix_q.size() > 0) && (pix_q[0].cyc == cyc);
      check("pixel_valid", 32'(pixel_valid), 32'(exp_v));
      if (exp_v) begin
        mp = pix_q.pop_front();
        if (pixel_valid) begin
          check("x", 32'(x), mp.x);
          check("y", 32'(y), mp.y);
          check("pixel_r", 32'($unsigned(pixel_r)), mp.r);
          check("pixel_g", 32'($unsigned(pixel_g)), mp.g);
          check("pixel_b", 32'($unsigned(pixel_b)), mp.b);
        end
      end else begin
        check("x_idle", 32'(x), 32'd0);
        check("y_idle", 32'(y), 32'd0);
      end
      exp_d = (done_q.size() > 0) && (done_q[0].cyc == cyc);
      check("frame_done", 32'(frame_done), 32'(exp_d));
      if (exp_d) begin
        md = done_q.pop_front();
        last_err = md.err;
        last_cnt = md.cnt;
      end
      check("frame_err", 32'(frame_err), last_err);
      check("frame_cnt", 32'(frame_cnt), last_cnt);
    end
  end

  task automatic drive(input logic f, input logic l, input logic d, input int v);
    @(posedge clk);
    #1;
    fval = f;
    lval = l;
    dval = d;
    cr = 12'(v);
    cg = 12'(v + 256);
    cb = 12'(4095 - v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic send_line(input int row, input int len, input bit fwd);
    int v;
    if (len == 0) begin
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 0);
    end else begin
      for (int c = 0; c < len; c++) begin
        v = 16 * row + c;
        drive(1'b1, 1'b1, 1'b1, v);
        if (fwd && row < H && c < W)
          pix_q.push_back('{x: 32'(c), y: 32'(row), r: 32'(v), g: 32'(v + 256),
                            b: 32'(4095 - v), cyc: cyc + 1});
      end
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
  endtask

  function automatic bit start_frame();
    bit fwd;
`ifdef FRAME_SKIP_EN
    fwd = (phase == 0);
    phase = (phase + 1) % SKIP;
`else
    fwd = 1'b1;
`endif
    return fwd;
  endfunction

  task automatic frame(input int nl, input int lens[6], input bit aligned);
    bit fwd;
    int rows;
    bit err;
    fwd = aligned ? start_frame() : 1'b0;
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    rows = 0;
    err = 1'b0;
    for (int i = 0; i < nl; i++) begin
      send_line(rows, lens[i], fwd);
      if (lens[i] != 0) begin
        if (rows >= H || lens[i] != W) err = 1'b1;
        if (rows < H) rows++;
      end
    end
    if (rows != H) err = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0);
    if (fwd) begin
      exp_cnt = (exp_cnt + 1) % 65536;
      done_q.push_back('{err: 32'(err), cnt: 32'(exp_cnt), cyc: cyc + 2});
    end
    idle(3);
  endtask

  task automatic reset_dut(input logic f, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      fval = f;
      lval = 1'b0;
      dval = 1'b0;
    end
    exp_cnt = 0;
    phase = 0;
    @(negedge clk);
    check("rst_pixel_r", 32'($unsigned(pixel_r)), 32'd0);
    check("rst_pixel_g", 32'($unsigned(pixel_g)), 32'd0);
    check("rst_pixel_b", 32'($unsigned(pixel_b)), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int clean[6] = '{8, 8, 8, 8, 0, 0};
  int long_l[6] = '{8, 10, 8, 8, 0, 0};
  int short_f[6] = '{8, 0, 6, 8, 0, 0};

  initial begin
    reset_dut(1'b0, 3);
    idle(2);

    // 1: clean frame
    frame(4, clean, 1'b1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("t1_frame_err", 32'(frame_err), 32'd0);

    // 2: reset released mid-frame; remainder and the next line ignored
    reset_dut(1'b1, 3);
    frame(2, clean, 1'b0);
    frame(4, clean, 1'b1);
    check("t2_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // 3: overlong line, then clean frame
    frame(4, long_l, 1'b1);
    frame(4, clean, 1'b1);

    // 4: three real lines, one short, plus an empty lval pulse
    frame(4, short_f, 1'b1);

    // 5: reset at row 2 col 3, then two clean frames
    begin
      bit fwd;
      fwd = start_frame();
      drive(1'b1, 1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 1'b0, 0);
      send_line(0, 8, fwd);
      send_line(1, 8, fwd);
      send_line(2, 3, fwd);
    end
    reset_dut(1'b1, 2);
    send_line(0, 8, 1'b0);
    idle(3);
    frame(4, clean, 1'b1);
    frame(4, clean, 1'b1);
    check("t5_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // 6: five clean frames (decimated when FRAME_SKIP_EN is defined)
    for (int i = 0; i < 5; i++) frame(4, clean, 1'b1);
    idle(5);
    check("t6_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
